// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous 16-bit RAM between loader, data and fetch
// requesters using fixed 3-cycle transactions. Define MEM_ARB_RR_EN for round-robin data/fetch.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [15:0]       ld_addr,
    input  logic [15:0]       ld_wdata,
    output logic              ld_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [15:0]       d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    input  logic              f_req,
    input  logic [15:0]       f_addr,
    output logic              f_ack,
    output logic [15:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);
    localparam logic [1:0] GntNone  = 2'b00;
    localparam logic [1:0] GntLd    = 2'b01;
    localparam logic [1:0] GntData  = 2'b10;
    localparam logic [1:0] GntFetch = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e              r_state, w_state_d;
    logic [1:0]          r_grant, w_grant_d, w_win;
    logic                r_we, w_sel_we;
    logic [ADDR_W-1:0]   r_addr, w_sel_addr;
    logic [15:0]         r_wdata, w_sel_wdata;
    logic                w_fetch_first;
    logic                w_done;
    logic                w_unused_addr;

    assign w_unused_addr = ^{ld_addr[15:ADDR_W], d_addr[15:ADDR_W], f_addr[15:ADDR_W]};

`ifdef MEM_ARB_RR_EN
    logic r_last_fetch, w_last_fetch_d;
    assign w_fetch_first = !r_last_fetch;
`else
    logic [3:0] r_starve, w_starve_d;
    assign w_fetch_first = (r_starve >= 4'(STARVE_LIMIT));
`endif

    // Loader has absolute priority; data/fetch ties resolved by the fairness policy.
    always_comb begin
        w_win = GntNone;
        if (ld_req) begin
            w_win = GntLd;
        end else if (d_req && f_req) begin
            w_win = w_fetch_first ? GntFetch : GntData;
        end else if (d_req) begin
            w_win = GntData;
        end else if (f_req) begin
            w_win = GntFetch;
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = f_addr[ADDR_W-1:0];
        w_sel_wdata = '0;
        case (w_win)
            GntLd: begin
                w_sel_we    = ld_we;
                w_sel_addr  = ld_addr[ADDR_W-1:0];
                w_sel_wdata = ld_wdata;
            end
            GntData: begin
                w_sel_we    = d_we;
                w_sel_addr  = d_addr[ADDR_W-1:0];
                w_sel_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
`ifdef MEM_ARB_RR_EN
        w_last_fetch_d = r_last_fetch;
`else
        w_starve_d = r_starve;
`endif
        case (r_state)
            StIdle: begin
                if (w_win != GntNone) begin
                    w_state_d = StIssue;
                    w_grant_d = w_win;
                end
`ifdef MEM_ARB_RR_EN
                if (w_win == GntData) begin
                    w_last_fetch_d = 1'b0;
                end else if (w_win == GntFetch) begin
                    w_last_fetch_d = 1'b1;
                end
`else
                if (f_req && w_win != GntFetch) begin
                    w_starve_d = (r_starve == 4'hF) ? r_starve : r_starve + 4'd1;
                end else begin
                    w_starve_d = '0;
                end
`endif
            end
            StIssue: w_state_d = StDone;
            StDone: begin
                w_state_d = StIdle;
                w_grant_d = GntNone;
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = GntNone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_grant <= GntNone;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_fetch <= 1'b1;
`else
            r_starve <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
`ifdef MEM_ARB_RR_EN
            r_last_fetch <= w_last_fetch_d;
`else
            r_starve <= w_starve_d;
`endif
            if (r_state == StIdle && w_win != GntNone) begin
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    // Gating by rst keeps a write in flight from landing when reset hits during ISSUE.
    assign mem_en    = (r_state == StIssue) && !rst;
    assign mem_we    = mem_en && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign w_done = (r_state == StDone);
    assign ld_ack = w_done && (r_grant == GntLd);
    assign d_ack  = w_done && (r_grant == GntData);
    assign f_ack  = w_done && (r_grant == GntFetch);
    assign rdata  = w_done ? mem_rdata : '0;
    assign grant  = r_grant;
    assign busy   = (r_state != StIdle);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model and shadow memory. Honours MEM_ARB_RR_EN like the design.
module tb_mem_arbiter;
    localparam int unsigned AW  = 10;
    localparam int unsigned LIM = 4;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_next = 1'b1;
    logic        req[3]     = '{1'b0, 1'b0, 1'b0};
    logic        we_i[3]    = '{1'b0, 1'b0, 1'b0};
    logic [15:0] addr_i[3]  = '{16'h0, 16'h0, 16'h0};
    logic [15:0] wdata_i[3] = '{16'h0, 16'h0, 16'h0};

    logic          ld_ack, d_ack, f_ack, mem_en, mem_we, busy;
    logic [15:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;

    logic [15:0] ram[1 << AW] = '{default: 16'h0};
    logic [15:0] ram_q = 16'h0;

    // Reference model state
    int          m_phase = 0;
    logic [1:0]  m_owner = 2'd0;
    logic        m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [15:0] m_wdata = 16'h0;
    int          m_starve = 0;
    bit          m_last_fetch = 1'b1;
    logic [15:0] shadow[1 << AW] = '{default: 16'h0};

    txn_t        pq[3][$];
    int          log_q[$];
    int          ack_cyc[$];
    logic [15:0] last_rd[3];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .ld_req(req[0]), .ld_we(we_i[0]), .ld_addr(addr_i[0]), .ld_wdata(wdata_i[0]),
        .ld_ack(ld_ack),
        .d_req(req[1]), .d_we(we_i[1]), .d_addr(addr_i[1]), .d_wdata(wdata_i[1]),
        .d_ack(d_ack),
        .f_req(req[2]), .f_addr(addr_i[2]), .f_ack(f_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic we, input logic [15:0] a, input logic [15:0] wd);
        txn_t t;
        t.we    = (p == 2) ? 1'b0 : we;
        t.addr  = a;
        t.wdata = wd;
        pq[p].push_back(t);
    endtask

    task automatic drive();
        logic [2:0] acks;
        txn_t t;
        acks = {f_ack, d_ack, ld_ack};
        for (int p = 0; p < 3; p++) begin
            if (rst) begin
                req[p] = 1'b0;
                continue;
            end
            if (req[p] && acks[p]) begin
                last_rd[p] = rdata;
                log_q.push_back(p + 1);
                ack_cyc.push_back(cyc);
                req[p] = 1'b0;
            end
            if (!req[p] && pq[p].size() > 0) begin
                t = pq[p].pop_front();
                req[p]     = 1'b1;
                we_i[p]    = t.we;
                addr_i[p]  = t.addr;
                wdata_i[p] = t.wdata;
            end
        end
    endtask

    task automatic compare();
        logic [1:0] eg;
        logic       een;
        logic [2:0] eack;
        eg   = (m_phase == 0) ? 2'd0 : m_owner;
        een  = (m_phase == 1) && !rst;
        eack = 3'b000;
        if (m_phase == 2) eack[m_owner - 2'd1] = 1'b1;
        check("ctl", {56'h0, grant, busy, mem_en, mem_we, f_ack, d_ack, ld_ack},
              {56'h0, eg, 1'(m_phase != 0), een, een && m_we, eack});
        if (een) begin
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        if (m_phase == 2 && !m_we) check("rdata", 64'(rdata), 64'(shadow[m_addr]));
    endtask

    task automatic advance();
        int  w;
        bit  fetch_wins;
        if (rst) begin
            m_phase = 0;
            m_starve = 0;
            m_last_fetch = 1'b1;
            return;
        end
        if (m_phase == 0) begin
`ifdef MEM_ARB_RR_EN
            fetch_wins = m_last_fetch ? 1'b0 : 1'b1;
`else
            fetch_wins = (m_starve >= int'(LIM));
`endif
            if (req[0]) w = 1;
            else if (req[1] && req[2]) w = fetch_wins ? 3 : 2;
            else if (req[1]) w = 2;
            else if (req[2]) w = 3;
            else w = 0;
            if (req[2] && w != 3) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else m_starve = 0;
            if (w == 2) m_last_fetch = 1'b0;
            if (w == 3) m_last_fetch = 1'b1;
            if (w != 0) begin
                m_owner = 2'(w);
                m_we    = (w == 3) ? 1'b0 : we_i[w-1];
                m_addr  = addr_i[w-1][AW-1:0];
                m_wdata = wdata_i[w-1];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_we) shadow[m_addr] = m_wdata;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        rst = rst_next;
        drive();
        #1;
        compare();
        advance();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pq[0].size() + pq[1].size() + pq[2].size() > 0 || req[0] || req[1] || req[2]
                || m_phase != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check("timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int          ord, pat, epat, n;
        logic [15:0] ra;

        cycle();
        cycle();
        check("rst_datapath", {22'h0, mem_addr, mem_wdata, rdata}, 64'h0);
        rst_next = 1'b0;

        // Data write then fetch read of the same word
        push(1, 1'b1, 16'h0005, 16'hBEEF);
        wait_idle(50);
        push(2, 1'b0, 16'h0005, 16'h0);
        wait_idle(50);
        check("fetch_beef", 64'(last_rd[2]), 64'hBEEF);

        // All three at once: loader, data, fetch, acks 3 cycles apart
        log_q.delete();
        ack_cyc.delete();
        push(0, 1'b0, 16'h0020, 16'h0);
        push(1, 1'b0, 16'h0021, 16'h0);
        push(2, 1'b0, 16'h0022, 16'h0);
        wait_idle(50);
        check("order_n", 64'(log_q.size()), 64'd3);
        ord = log_q[0] * 16 + log_q[1] * 4 + log_q[2];
        check("order", 64'(ord), 64'd27);
        check("ack_gap0", 64'(ack_cyc[1] - ack_cyc[0]), 64'd3);
        check("ack_gap1", 64'(ack_cyc[2] - ack_cyc[1]), 64'd3);

        // Continuous data traffic with fetch pending
        log_q.delete();
        for (int i = 0; i < 12; i++) push(1, 1'b0, 16'(i), 16'h0);
        for (int i = 0; i < 3; i++) push(2, 1'b0, 16'(i + 32), 16'h0);
        wait_idle(200);
        pat = 0;
        epat = 0;
        for (int i = 0; i < 10; i++) begin
            pat = pat * 4 + log_q[i];
`ifdef MEM_ARB_RR_EN
            epat = epat * 4 + ((i < 6 && i % 2 == 1) ? 3 : 2);
`else
            epat = epat * 4 + ((i % 5 == 4) ? 3 : 2);
`endif
        end
        check("fairness", 64'(pat), 64'(epat));

        // Reset during ISSUE of a write
        push(1, 1'b1, 16'h0010, 16'h5555);
        wait_idle(50);
        log_q.delete();
        push(1, 1'b1, 16'h0010, 16'h1234);
        n = 0;
        do begin
            cycle();
            n++;
        end while (m_phase != 1 && n < 20);
        check("reach_issue", 64'(m_phase), 64'd1);
        rst_next = 1'b1;
        cycle();
        check("rst_mem_we", {62'h0, mem_en, mem_we}, 64'h0);
        rst_next = 1'b0;
        cycle();
        check("rst_idle", 64'(busy), 64'd0);
        push(2, 1'b0, 16'h0010, 16'h0);
        wait_idle(50);
        check("rst_keep", 64'(last_rd[2]), 64'h5555);
        check("rst_noack", 64'(log_q.size()), 64'd1);

        // Address aliasing above ADDR_W
        push(1, 1'b1, 16'h0407, 16'h00AA);
        wait_idle(50);
        push(2, 1'b0, 16'h0007, 16'h0);
        wait_idle(50);
        check("alias", 64'(last_rd[2]), 64'h00AA);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (pq[p].size() < 2 && $urandom_range(0, 3) == 0) begin
                    ra = {6'($urandom), 6'd0, 4'($urandom)};
                    push(p, 1'($urandom), ra, 16'($urandom));
                end
            end
            cycle();
        end
        wait_idle(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
